// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle from the VGA sync generator to the renderer and output pins.
interface vga_sync_gen_if;
  logic       hsync_o;
  logic       vsync_o;
  logic       video_on_o;
  logic [9:0] x_o;
  logic [9:0] y_o;
  logic       line_start_o;
  logic       frame_start_o;

  modport master (
    output hsync_o, vsync_o, video_on_o, x_o, y_o, line_start_o, frame_start_o
  );

  modport slave (
    input hsync_o, vsync_o, video_on_o, x_o, y_o, line_start_o, frame_start_o
  );
endinterface

// File: rtl/vga_sync_gen.sv
// Free-running VGA raster generator: h/v counters plus registered, zero-skew sync,
// video-on, coordinate and line/frame strobe outputs.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  vga_sync_gen_if.master vga
);

  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
  localparam int unsigned CW        = $clog2(MAX_TOTAL);
  localparam int unsigned HS_START  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END    = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int unsigned VS_START  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END    = V_ACTIVE + V_FP + V_SYNC - 1;

  logic [CW-1:0] h_cnt, v_cnt;
  logic [CW-1:0] h_nxt_c, v_nxt_c;
  logic          running;
  logic          hs_act_c, vs_act_c, video_c, line_c, frame_c;

  // Next raster position; held at (0,0) on the first edge after reset so pixel 0 is shown.
  always_comb begin
    h_nxt_c = h_cnt;
    v_nxt_c = v_cnt;
    if (running) begin
      if (h_cnt == CW'(H_TOTAL - 1)) begin
        h_nxt_c = '0;
        if (v_cnt == CW'(V_TOTAL - 1)) begin
          v_nxt_c = '0;
        end else begin
          v_nxt_c = v_cnt + CW'(1);
        end
      end else begin
        h_nxt_c = h_cnt + CW'(1);
      end
    end
  end

  // Decode from the next position so the registered outputs line up with x_o/y_o.
  always_comb begin
    hs_act_c = (h_nxt_c >= CW'(HS_START)) && (h_nxt_c <= CW'(HS_END));
    vs_act_c = (v_nxt_c >= CW'(VS_START)) && (v_nxt_c <= CW'(VS_END));
    video_c  = (h_nxt_c < CW'(H_ACTIVE)) && (v_nxt_c < CW'(V_ACTIVE));
    line_c   = (h_nxt_c == '0);
    frame_c  = (h_nxt_c == '0) && (v_nxt_c == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      running           <= 1'b0;
      h_cnt             <= '0;
      v_cnt             <= '0;
      vga.hsync_o       <= ~SYNC_POL;
      vga.vsync_o       <= ~SYNC_POL;
      vga.video_on_o    <= 1'b0;
      vga.x_o           <= '0;
      vga.y_o           <= '0;
      vga.line_start_o  <= 1'b0;
      vga.frame_start_o <= 1'b0;
    end else begin
      running           <= 1'b1;
      h_cnt             <= h_nxt_c;
      v_cnt             <= v_nxt_c;
      vga.hsync_o       <= hs_act_c ? SYNC_POL : ~SYNC_POL;
      vga.vsync_o       <= vs_act_c ? SYNC_POL : ~SYNC_POL;
      vga.video_on_o    <= video_c;
      vga.x_o           <= 10'(h_nxt_c);
      vga.y_o           <= 10'(v_nxt_c);
      vga.line_start_o  <= line_c;
      vga.frame_start_o <= frame_c;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default 640x480 timing on line boundaries and a
// small-parameter instance checked cycle by cycle over three frames.
module tb_vga_sync_gen;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_s = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if vif ();
  vga_sync_gen_if vif_s ();

  vga_sync_gen dut (.clk_i(clk), .rst_i(rst), .vga(vif.master));

  vga_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1)
  ) dut_s (.clk_i(clk), .rst_i(rst_s), .vga(vif_s.master));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packed view: {hsync, vsync, video_on, line_start, frame_start, x, y}
  logic [24:0] got, exp;

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      got = {vif.hsync_o, vif.vsync_o, vif.video_on_o, vif.line_start_o, vif.frame_start_o, vif.x_o, vif.y_o};
      exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, got, exp);
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if (vif.x_o !== 10'd0 || vif.y_o !== 10'd0) begin
      errors++;
      $display("FAIL release_pos got=(%0d,%0d) exp=(0,0)", vif.x_o, vif.y_o);
    end
    checks++;
    if (vif.video_on_o !== 1'b1) begin
      errors++;
      $display("FAIL release_video got=%b exp=1", vif.video_on_o);
    end
    checks++;
    if (vif.line_start_o !== 1'b1 || vif.frame_start_o !== 1'b1) begin
      errors++;
      $display("FAIL release_strobes got=%b%b exp=11", vif.line_start_o, vif.frame_start_o);
    end
    step();
    checks++;
    if (vif.x_o !== 10'd1 || vif.line_start_o !== 1'b0 || vif.frame_start_o !== 1'b0) begin
      errors++;
      $display("FAIL second_pixel got x=%0d ls=%b fs=%b exp x=1 ls=0 fs=0",
               vif.x_o, vif.line_start_o, vif.frame_start_o);
    end
  endtask

  task automatic test_horizontal();
    int hs_low = 0;
    int vo_cnt = 2;
    for (int x = 2; x < 800; x++) begin
      step();
      got = {vif.hsync_o, vif.vsync_o, vif.video_on_o, vif.line_start_o, vif.frame_start_o, vif.x_o, vif.y_o};
      exp = {!(x >= 656 && x <= 751), 1'b1, (x < 640), 1'b0, 1'b0, 10'(x), 10'd0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL line0 x=%0d got=%h exp=%h", x, got, exp);
      end
      if (vif.hsync_o == 1'b0) hs_low++;
      if (vif.video_on_o == 1'b1) vo_cnt++;
    end
    checks++;
    if (hs_low != 96) begin
      errors++;
      $display("FAIL hsync_width got=%0d exp=96", hs_low);
    end
    checks++;
    if (vo_cnt != 640) begin
      errors++;
      $display("FAIL video_width got=%0d exp=640", vo_cnt);
    end
    step();
    got = {vif.hsync_o, vif.vsync_o, vif.video_on_o, vif.line_start_o, vif.frame_start_o, vif.x_o, vif.y_o};
    exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd1};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL line_wrap got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_mid_reset();
    // From (0,1) walk to (300,2)
    for (int i = 0; i < 1100; i++) step();
    checks++;
    if (vif.x_o !== 10'd300 || vif.y_o !== 10'd2) begin
      errors++;
      $display("FAIL walk_pos got=(%0d,%0d) exp=(300,2)", vif.x_o, vif.y_o);
    end
    rst = 1'b1;
    step();
    got = {vif.hsync_o, vif.vsync_o, vif.video_on_o, vif.line_start_o, vif.frame_start_o, vif.x_o, vif.y_o};
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL mid_reset got=%h exp=%h", got, exp);
    end
    rst = 1'b0;
    step();
    got = {vif.hsync_o, vif.vsync_o, vif.video_on_o, vif.line_start_o, vif.frame_start_o, vif.x_o, vif.y_o};
    exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL mid_reset_release got=%h exp=%h", got, exp);
    end
    step();
    checks++;
    if (vif.x_o !== 10'd1 || vif.y_o !== 10'd0) begin
      errors++;
      $display("FAIL mid_reset_advance got=(%0d,%0d) exp=(1,0)", vif.x_o, vif.y_o);
    end
  endtask

  task automatic test_small_frames();
    int last_fs = -1;
    int fs_cnt  = 0;
    int x, y;
    // Reset state with active-high sync polarity: inactive level is 0
    got = {vif_s.hsync_o, vif_s.vsync_o, vif_s.video_on_o, vif_s.line_start_o, vif_s.frame_start_o, vif_s.x_o, vif_s.y_o};
    exp = '0;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL small_reset got=%h exp=%h", got, exp);
    end
    rst_s = 1'b0;
    for (int k = 0; k < 3 * 48; k++) begin
      step();
      x = k % 8;
      y = (k / 8) % 6;
      got = {vif_s.hsync_o, vif_s.vsync_o, vif_s.video_on_o, vif_s.line_start_o, vif_s.frame_start_o, vif_s.x_o, vif_s.y_o};
      exp = {(x == 5 || x == 6), (y == 4), (x < 4 && y < 3), (x == 0), (x == 0 && y == 0), 10'(x), 10'(y)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL small k=%0d (%0d,%0d) got=%h exp=%h", k, x, y, got, exp);
      end
      if (vif_s.frame_start_o == 1'b1) begin
        if (last_fs >= 0) begin
          checks++;
          if (k - last_fs != 48) begin
            errors++;
            $display("FAIL frame_period got=%0d exp=48", k - last_fs);
          end
        end
        last_fs = k;
        fs_cnt++;
      end
    end
    checks++;
    if (fs_cnt != 3) begin
      errors++;
      $display("FAIL frame_count got=%0d exp=3", fs_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_mid_reset();
    test_small_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
